// File: rtl/crc_recv_if.sv
// Word stream into the CRC receiver and the forwarded-payload / frame-status stream out of it.
interface crc_recv_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_in_valid;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_out_valid;
   logic                  frame_done;
   logic                  crc_ok;
   logic                  crc_err;
   logic                  busy;

   modport master (
      output data_in, data_in_valid,
      input  data_out, data_out_valid, frame_done, crc_ok, crc_err, busy
   );

   modport slave (
      input  data_in, data_in_valid,
      output data_out, data_out_valid, frame_done, crc_ok, crc_err, busy
   );
endinterface

// File: rtl/crc_recv.sv
// CRC-32 frame receiver: forwards FRAME_LEN payload words, checks the trailing CRC word,
// pulses pass/fail per frame and keeps a saturating failed-frame count.
module crc_recv #(
   parameter int          DATA_WIDTH = 32,
   parameter int          FRAME_LEN  = 4,
   parameter logic [31:0] POLY       = 32'h04C11DB7,
   parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF
) (
   input  logic        axis_aclk,
   input  logic        axis_aresetn,
   crc_recv_if.slave   bus,
   input  logic        clear_errs,
   output logic [15:0] err_count
);

   typedef enum logic [1:0] {IDLE, DATA, CRCW} state_t;

   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   state_t                state_q, state_d;
   logic [31:0]           crc_q, crc_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dv_q, dv_d;
   logic                  done_q, done_d;
   logic                  ok_q, ok_d;
   logic                  err_q, err_d;
   logic [15:0]           errcnt_q, errcnt_d;

   // MSB-first bit-serial CRC update, fully unrolled.
   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] w);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int unsigned k = 0; k < 32; k++) begin
         fb = c[31] ^ w[31 - k];
         c  = {c[30:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q  <= IDLE;
         crc_q    <= CRC_INIT;
         cnt_q    <= '0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         done_q   <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         crc_q    <= crc_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      crc_d    = crc_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      dv_d     = 1'b0;
      done_d   = 1'b0;
      ok_d     = 1'b0;
      err_d    = 1'b0;
      errcnt_d = errcnt_q;

      case (state_q)
         IDLE: begin
            if (bus.data_in_valid) begin
               crc_d   = crc_step(crc_q, bus.data_in);
               cnt_d   = 16'd1;
               dout_d  = bus.data_in;
               dv_d    = 1'b1;
               state_d = (FRAME_LEN == 1) ? CRCW : DATA;
            end
         end
         DATA: begin
            if (bus.data_in_valid) begin
               crc_d  = crc_step(crc_q, bus.data_in);
               cnt_d  = cnt_q + 16'd1;
               dout_d = bus.data_in;
               dv_d   = 1'b1;
               if (cnt_q == LAST_IDX) state_d = CRCW;
            end
         end
         CRCW: begin
            // Comparing against the running CRC is equivalent to a zero residue.
            if (bus.data_in_valid) begin
               done_d  = 1'b1;
               ok_d    = (bus.data_in == crc_q);
               err_d   = (bus.data_in != crc_q);
               crc_d   = CRC_INIT;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear_errs)
         errcnt_d = '0;
      else if (err_d && (errcnt_q != 16'hFFFF))
         errcnt_d = errcnt_q + 16'd1;
   end

   assign bus.data_out       = dout_q;
   assign bus.data_out_valid = dv_q;
   assign bus.frame_done     = done_q;
   assign bus.crc_ok         = ok_q;
   assign bus.crc_err        = err_q;
   assign bus.busy           = (state_q != IDLE);
   assign err_count          = errcnt_q;

endmodule

// File: tb/tb_crc_recv.sv
// Checks crc_recv (FRAME_LEN=1 and FRAME_LEN=4 instances) against a frame-level reference model.
module tb_crc_recv;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] din [2];
   logic        vld [2];
   logic        clr [2];
   logic [15:0] ec0, ec1;

   always #5 clk = ~clk;

   crc_recv_if #(.DATA_WIDTH(32)) if0 ();
   crc_recv_if #(.DATA_WIDTH(32)) if1 ();

   assign if0.data_in       = din[0];
   assign if0.data_in_valid = vld[0];
   assign if1.data_in       = din[1];
   assign if1.data_in_valid = vld[1];

   crc_recv #(.DATA_WIDTH(32), .FRAME_LEN(1), .POLY(POLY), .CRC_INIT(INIT)) u0 (
      .axis_aclk(clk), .axis_aresetn(rstn), .bus(if0.slave), .clear_errs(clr[0]), .err_count(ec0)
   );
   crc_recv #(.DATA_WIDTH(32), .FRAME_LEN(4), .POLY(POLY), .CRC_INIT(INIT)) u1 (
      .axis_aclk(clk), .axis_aresetn(rstn), .bus(if1.slave), .clear_errs(clr[1]), .err_count(ec1)
   );

   logic [31:0] a_dout [2];
   logic        a_dv [2], a_fd [2], a_ok [2], a_err [2], a_busy [2];
   logic [15:0] a_ec [2];
   assign a_dout[0] = if0.data_out;       assign a_dout[1] = if1.data_out;
   assign a_dv[0]   = if0.data_out_valid; assign a_dv[1]   = if1.data_out_valid;
   assign a_fd[0]   = if0.frame_done;     assign a_fd[1]   = if1.frame_done;
   assign a_ok[0]   = if0.crc_ok;         assign a_ok[1]   = if1.crc_ok;
   assign a_err[0]  = if0.crc_err;        assign a_err[1]  = if1.crc_err;
   assign a_busy[0] = if0.busy;           assign a_busy[1] = if1.busy;
   assign a_ec[0]   = ec0;                assign a_ec[1]   = ec1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[dut%0d] got=%h expected=%h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Reference CRC by augmented polynomial division: init folded into the first word,
   // 32 zero bits appended, remainder taken modulo POLY.
   function automatic logic [31:0] ref_crc(input logic [31:0] w [4], input int n);
      logic [31:0] r;
      logic [31:0] word;
      logic        top;
      r = '0;
      for (int i = 0; i <= n; i++) begin
         word = (i == n) ? 32'h0 : (w[i] ^ ((i == 0) ? INIT : 32'h0));
         for (int b = 31; b >= 0; b--) begin
            top = r[31];
            r   = {r[30:0], word[b]};
            if (top) r = r ^ POLY;
         end
      end
      return r;
   endfunction

   // Frame-level behavioural model
   int          fl [2];
   int          mcnt [2];
   logic [31:0] mw [2][4];
   logic [31:0] e_dout [2];
   logic        e_dv [2], e_fd [2], e_ok [2], e_err [2];
   logic [15:0] e_ec [2];
   int          dv_cnt [2], fd_cnt [2], ok_cnt [2];

   initial begin
      fl[0] = 1; fl[1] = 4;
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; e_dout[k] = '0; e_dv[k] = 0; e_fd[k] = 0; e_ok[k] = 0; e_err[k] = 0;
         e_ec[k] = '0; dv_cnt[k] = 0; fd_cnt[k] = 0; ok_cnt[k] = 0;
      end
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            logic [31:0] tmp [4];
            logic [31:0] c;
            e_dv[k] = 0; e_fd[k] = 0; e_ok[k] = 0; e_err[k] = 0;
            if (!rstn) begin
               mcnt[k] = 0; e_dout[k] = '0; e_ec[k] = '0;
            end else begin
               if (vld[k]) begin
                  if (mcnt[k] < fl[k]) begin
                     mw[k][mcnt[k]] = din[k];
                     e_dout[k] = din[k];
                     e_dv[k] = 1;
                     mcnt[k]++;
                  end else begin
                     for (int j = 0; j < 4; j++) tmp[j] = mw[k][j];
                     c = ref_crc(tmp, fl[k]);
                     e_fd[k] = 1;
                     e_ok[k] = (din[k] == c);
                     e_err[k] = !e_ok[k];
                     mcnt[k] = 0;
                  end
               end
               if (clr[k]) e_ec[k] = '0;
               else if (e_err[k] && e_ec[k] != 16'hFFFF) e_ec[k] = e_ec[k] + 16'd1;
            end
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            chk("data_out_valid", k, {31'b0, a_dv[k]}, {31'b0, e_dv[k]});
            chk("data_out", k, a_dout[k], e_dout[k]);
            chk("frame_done", k, {31'b0, a_fd[k]}, {31'b0, e_fd[k]});
            chk("crc_ok", k, {31'b0, a_ok[k]}, {31'b0, e_ok[k]});
            chk("crc_err", k, {31'b0, a_err[k]}, {31'b0, e_err[k]});
            chk("busy", k, {31'b0, a_busy[k]}, {31'b0, (mcnt[k] != 0)});
            chk("err_count", k, {16'b0, a_ec[k]}, {16'b0, e_ec[k]});
            if (a_dv[k]) dv_cnt[k]++;
            if (a_fd[k]) fd_cnt[k]++;
            if (a_ok[k]) ok_cnt[k]++;
         end
      end
   end

   task automatic send(input int k, input logic [31:0] w, input logic c);
      @(negedge clk);
      vld[0] = 0; vld[1] = 0; clr[0] = 0; clr[1] = 0;
      din[k] = w; vld[k] = 1; clr[k] = c;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vld[0] = 0; vld[1] = 0; clr[0] = 0; clr[1] = 0;
      end
   endtask

   task automatic send4(input logic [31:0] w3, input logic [31:0] crc, input logic c);
      send(1, 32'hFFFFFFFF, 0); send(1, 32'h0, 0); send(1, 32'h0, 0); send(1, w3, 0);
      send(1, crc, c);
   endtask

   initial begin
      logic [31:0] t [4];
      int f0, o0;
      din[0] = 32'hDEADBEEF; din[1] = 32'h12345678;
      vld[0] = 1; vld[1] = 1; clr[0] = 0; clr[1] = 0;

      // Pin the reference model against hand-computed values
      t[0] = 32'hFFFFFFFE; t[1] = 0; t[2] = 0; t[3] = 0;
      chk("ref_crc_len1", 0, ref_crc(t, 1), 32'h04C11DB7);
      t[0] = 32'hFFFFFFFF;
      chk("ref_crc_len4_zero", 1, ref_crc(t, 4), 32'h00000000);
      t[3] = 32'h1;
      chk("ref_crc_len4_one", 1, ref_crc(t, 4), 32'h04C11DB7);

      // Reset held with valid input
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_dv", k, {31'b0, a_dv[k]}, 32'h0);
         chk("rst_busy", k, {31'b0, a_busy[k]}, 32'h0);
         chk("rst_dout", k, a_dout[k], 32'h0);
      end
      vld[0] = 0; vld[1] = 0;
      rstn = 1;
      idle(2);

      // FRAME_LEN=1 pass
      send(0, 32'hFFFFFFFE, 0);
      send(0, 32'h04C11DB7, 0);
      chk("fl1_dout", 0, a_dout[0], 32'hFFFFFFFE);
      chk("fl1_dv", 0, {31'b0, a_dv[0]}, 32'h1);
      idle(1);
      chk("fl1_done", 0, {31'b0, a_fd[0]}, 32'h1);
      chk("fl1_ok", 0, {31'b0, a_ok[0]}, 32'h1);
      chk("fl1_errcnt", 0, {16'b0, ec0}, 32'h0);

      // FRAME_LEN=4 passes, failure, clear coinciding with a failure
      send4(32'h0, 32'h0, 0); idle(1);
      chk("fl4_ok_a", 1, {31'b0, a_ok[1]}, 32'h1);
      send4(32'h1, 32'h04C11DB7, 0); idle(1);
      chk("fl4_ok_b", 1, {31'b0, a_ok[1]}, 32'h1);
      send4(32'h0, 32'h1, 0); idle(1);
      chk("fl4_err", 1, {31'b0, a_err[1]}, 32'h1);
      chk("fl4_errcnt1", 1, {16'b0, ec1}, 32'h1);
      send4(32'h0, 32'h1, 1); idle(1);
      chk("fl4_err2", 1, {31'b0, a_err[1]}, 32'h1);
      chk("fl4_errcnt_clr", 1, {16'b0, ec1}, 32'h0);

      // Gap inside a frame
      send(1, 32'hFFFFFFFF, 0); send(1, 32'h0, 0); idle(3);
      send(1, 32'h0, 0); send(1, 32'h1, 0); send(1, 32'h04C11DB7, 0); idle(1);
      chk("gap_ok", 1, {31'b0, a_ok[1]}, 32'h1);

      // Back-to-back frames
      f0 = fd_cnt[1]; o0 = ok_cnt[1];
      send4(32'h0, 32'h0, 0); send4(32'h1, 32'h04C11DB7, 0); idle(2);
      chk("b2b_done", 1, fd_cnt[1] - f0, 2);
      chk("b2b_ok", 1, ok_cnt[1] - o0, 2);

      // Reset after two payload words
      send(1, 32'hAAAA5555, 0); send(1, 32'h13572468, 0); idle(1);
      rstn = 0; idle(2); rstn = 1;
      dv_cnt[1] = 0;
      send4(32'h0, 32'h0, 0); idle(1);
      chk("mid_rst_ok", 1, {31'b0, a_ok[1]}, 32'h1);
      idle(2);
      chk("mid_rst_dv_cnt", 1, dv_cnt[1], 4);

      // Randomized frames with gaps and clears
      for (int n = 0; n < 200; n++) begin
         int k;
         logic [31:0] c;
         k = int'($urandom_range(1, 0));
         for (int j = 0; j < 4; j++) t[j] = $urandom;
         c = ref_crc(t, fl[k]);
         if ($urandom_range(3, 0) == 0) c = c ^ (32'h1 << $urandom_range(31, 0));
         for (int j = 0; j <= fl[k]; j++) begin
            send(k, (j == fl[k]) ? c : t[j], ($urandom_range(7, 0) == 0));
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
         end
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
